// File: rtl/sw_pkg.sv
// sw_pkg: shared types, base encodings and score clamp for the Smith-Waterman engine.
package sw_pkg;
   typedef logic [1:0] base_t;
   localparam base_t BASE_A = 2'b00;
   localparam base_t BASE_C = 2'b01;
   localparam base_t BASE_G = 2'b10;
   localparam base_t BASE_T = 2'b11;
   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
   function automatic int sat_clamp(input int v, input int hi);
      return v < 0 ? 0 : (v > hi ? hi : v);
   endfunction
endpackage

// File: rtl/sw_cell.sv
// sw_cell: one Smith-Waterman DP cell, signed candidates clamped to [0, 2^SCORE_W-1].
module sw_cell import sw_pkg::*; #(
   parameter int SCORE_W  = 6,
   parameter int MATCH    = 2,
   parameter int MISMATCH = 1,
   parameter int GAP      = 1
) (
   input  logic [SCORE_W-1:0] diag_i,
   input  logic [SCORE_W-1:0] up_i,
   input  logic [SCORE_W-1:0] left_i,
   input  base_t              a_i,
   input  base_t              b_i,
   output logic [SCORE_W-1:0] h_o
);
   localparam int CW = SCORE_W + 2;
   logic signed [CW-1:0] c_diag, c_up, c_left, best;
   always_comb begin
      c_diag = $signed({2'b00, diag_i}) + ((a_i == b_i) ? CW'(MATCH) : -CW'(MISMATCH));
      c_up   = $signed({2'b00, up_i}) - CW'(GAP);
      c_left = $signed({2'b00, left_i}) - CW'(GAP);
      best   = c_diag > c_up ? c_diag : c_up;
      best   = best > c_left ? best : c_left;
      h_o    = SCORE_W'(sat_clamp(int'(best), (1 << SCORE_W) - 1));
   end
endmodule

// File: rtl/sw_score_engine.sv
// sw_score_engine: sequential Smith-Waterman local-alignment scorer, one DP cell per clock.
// Define SW_ENDPOS_EN to add the end_i/end_j ports reporting where the maximum lies.
module sw_score_engine import sw_pkg::*; #(
   parameter int N        = 8,
   parameter int M        = 7,
   parameter int SCORE_W  = 6,
   parameter int MATCH    = 2,
   parameter int MISMATCH = 1,
   parameter int GAP      = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [2*N-1:0]         seq_a,
   input  logic [2*M-1:0]         seq_b,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [SCORE_W-1:0]     score
`ifdef SW_ENDPOS_EN
   ,
   output logic [$clog2(N+1)-1:0] end_i,
   output logic [$clog2(M+1)-1:0] end_j
`endif
);
   localparam int IW = $clog2(N + 1);
   localparam int JW = $clog2(M + 1);
   state_t             state_q;
   logic [IW-1:0]      i_q;
   logic [JW-1:0]      j_q;
   logic [2*N-1:0]     a_q;
   logic [2*M-1:0]     b_q;
   logic [SCORE_W-1:0] row_q [M];
   logic [SCORE_W-1:0] diag_q, left_q, max_q, h;
   logic               first, last_col, last;
`ifdef SW_ENDPOS_EN
   logic [IW-1:0]      end_i_q;
   logic [JW-1:0]      end_j_q;
   assign end_i = end_i_q;
   assign end_j = end_j_q;
`endif
   assign first    = j_q == JW'(1);
   assign last_col = j_q == JW'(M);
   assign last     = last_col && i_q == IW'(N);
   assign ready    = state_q == IDLE;
   assign busy     = state_q == FILL;
   assign done     = state_q == DONE;
   assign score    = max_q;
   // The row buffer rotates once per row, so its head is always H(i-1,j) and
   // the current bases are the low bits of the rotating sequence registers.
   sw_cell #(.SCORE_W(SCORE_W), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)) u_cell (
      .diag_i(first ? '0 : diag_q),
      .up_i  (row_q[0]),
      .left_i(first ? '0 : left_q),
      .a_i   (a_q[1:0]),
      .b_i   (b_q[1:0]),
      .h_o   (h)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         diag_q  <= '0;
         left_q  <= '0;
         max_q   <= '0;
         for (int k = 0; k < M; k++) row_q[k] <= '0;
`ifdef SW_ENDPOS_EN
         end_i_q <= '0;
         end_j_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q <= FILL;
               i_q     <= IW'(1);
               j_q     <= JW'(1);
               a_q     <= seq_a;
               b_q     <= seq_b;
               max_q   <= '0;
               for (int k = 0; k < M; k++) row_q[k] <= '0;
`ifdef SW_ENDPOS_EN
               end_i_q <= '0;
               end_j_q <= '0;
`endif
            end
            FILL: begin
               for (int k = 0; k < M - 1; k++) row_q[k] <= row_q[k+1];
               row_q[M-1] <= h;
               diag_q     <= row_q[0];
               left_q     <= h;
               b_q        <= {b_q[1:0], b_q[2*M-1:2]};
               j_q        <= last_col ? JW'(1) : j_q + JW'(1);
               if (h > max_q) begin
                  max_q   <= h;
`ifdef SW_ENDPOS_EN
                  end_i_q <= i_q;
                  end_j_q <= j_q;
`endif
               end
               if (last_col) begin
                  i_q <= i_q + IW'(1);
                  a_q <= a_q >> 2;
               end
               if (last) state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sw_score_engine.sv
// tb_sw_score_engine: random and directed runs checked against a full-matrix reference model.
module tb_sw_score_engine;
   import sw_pkg::*;
   localparam int N = 8, M = 7, W = 6, WS = 3, MATCH = 2, MISMATCH = 1, GAP = 1;
   logic clk = 0, rst = 1, start = 0;
   logic [2*N-1:0] seq_a = '0;
   logic [2*M-1:0] seq_b = '0;
   logic ready, busy, done, ready_s, busy_s, done_s;
   logic [W-1:0] score;
   logic [WS-1:0] score_s;
`ifdef SW_ENDPOS_EN
   logic [3:0] end_i, end_i_s;
   logic [2:0] end_j, end_j_s;
`endif
   int n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   sw_score_engine #(.N(N), .M(M), .SCORE_W(W), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .seq_a(seq_a), .seq_b(seq_b),
      .ready(ready), .busy(busy), .done(done), .score(score)
`ifdef SW_ENDPOS_EN
      , .end_i(end_i), .end_j(end_j)
`endif
   );
   sw_score_engine #(.N(N), .M(M), .SCORE_W(WS), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)) dut_s (
      .clk(clk), .rst(rst), .start(start), .seq_a(seq_a), .seq_b(seq_b),
      .ready(ready_s), .busy(busy_s), .done(done_s), .score(score_s)
`ifdef SW_ENDPOS_EN
      , .end_i(end_i_s), .end_j(end_j_s)
`endif
   );
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   function automatic logic [2*N-1:0] enc(input string s);
      logic [2*N-1:0] v = '0;
      for (int k = 0; k < s.len(); k++)
         v[2*k +: 2] = s[k] == "A" ? BASE_A : s[k] == "C" ? BASE_C : s[k] == "G" ? BASE_G : BASE_T;
      return v;
   endfunction
   // Whole DP matrix, row-major scan, strict-greater maximum.
   function automatic void ref_sw(input logic [2*N-1:0] a, input logic [2*M-1:0] b, input int w,
                                  output int sc, output int ei, output int ej);
      int h [N+1][M+1];
      int hi, v;
      hi = (1 << w) - 1;
      sc = 0; ei = 0; ej = 0;
      foreach (h[i, j]) h[i][j] = 0;
      for (int i = 1; i <= N; i++)
         for (int j = 1; j <= M; j++) begin
            v = h[i-1][j-1] + (a[2*i-2 +: 2] == b[2*j-2 +: 2] ? MATCH : -MISMATCH);
            if (h[i-1][j] - GAP > v) v = h[i-1][j] - GAP;
            if (h[i][j-1] - GAP > v) v = h[i][j-1] - GAP;
            v = v < 0 ? 0 : (v > hi ? hi : v);
            h[i][j] = v;
            if (v > sc) begin sc = v; ei = i; ej = j; end
         end
   endfunction
   task automatic run(input logic [2*N-1:0] a, input logic [2*M-1:0] b, input int poke, input int rcyc);
      int sc, ei, ej, ss, si, sj, cyc, nd;
      ref_sw(a, b, W, sc, ei, ej);
      ref_sw(a, b, WS, ss, si, sj);
      check("ready_before", ready, 1);
      seq_a = a; seq_b = b; start = 1;
      @(negedge clk);
      start = 0; seq_a = 16'($urandom); seq_b = 14'($urandom);
      check("busy_first", busy, 1);
      cyc = 1;
      while (!done && cyc < 2*N*M) begin
         if (cyc == poke) begin
            check("poke_ready", ready, 0);
            start = 1; seq_a = ~a; seq_b = ~b;
         end
         if (cyc == rcyc) begin
            rst = 1;
            #1;
            check("rst_ready", ready, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_score", score, 0);
            check("rst_score_s", score_s, 0);
            @(negedge clk);
            rst = 0; nd = 0;
            repeat (N*M + 5) begin @(negedge clk); nd += int'(done); end
            check("rst_no_done", nd, 0);
            return;
         end
         @(negedge clk);
         start = 0;
         cyc++;
      end
      check("latency", cyc, N*M + 1);
      check("done", done, 1);
      check("done_s", done_s, 1);
      check("score", score, sc);
      check("score_s", score_s, ss);
`ifdef SW_ENDPOS_EN
      check("end_i", end_i, ei);
      check("end_j", end_j, ej);
      check("end_i_s", end_i_s, si);
      check("end_j_s", end_j_s, sj);
`endif
      @(negedge clk);
      check("done_pulse", done, 0);
      check("ready_after", ready, 1);
      check("score_hold", score, sc);
   endtask
   initial begin
      logic [2*N-1:0] a;
      logic [2*M-1:0] b;
      repeat (2) @(negedge clk);
      check("reset_ready", ready, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_score", score, 0);
      rst = 0;
      @(negedge clk);
      run(enc("AAAAAAAA"), 14'(enc("AAAAAAA")), 0, 0);
      run(enc("AAAAAAAA"), 14'(enc("CCCCCCC")), 0, 0);
      run(enc("ACGTACGT"), 14'(enc("ACGACGT")), 0, 0);
      run(enc("AAAAAAAA"), 14'(enc("AAAAAAA")), 10, 0);
      run(enc("ACGTACGT"), 14'(enc("ACGACGT")), 0, 20);
      run(enc("ACGTACGT"), 14'(enc("ACGACGT")), 0, 0);
      for (int r = 0; r < 24; r++) begin
         a = 16'($urandom);
         b = r[0] ? a[2*M-1:0] ^ 14'(1 << $urandom_range(0, 2*M-1)) : 14'($urandom);
         run(a, b, 0, 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
